// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - value/control inputs and scan outputs of the seven-segment driver
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output value, load, dp_in, blank_mask, blink_mask, lz_en,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  value, load, dp_in, blank_mask, blink_mask, lz_en,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit seven-segment scanner with tear-free updates
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    seg7_scan_if.slave  bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [FW-1:0]           fcnt;
    logic                    phase;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] display;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_nib;
    logic                    upper_zero;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 7'b1111110;
            4'h1: seg_code = 7'b0110000;
            4'h2: seg_code = 7'b1101101;
            4'h3: seg_code = 7'b1111001;
            4'h4: seg_code = 7'b0110011;
            4'h5: seg_code = 7'b1011011;
            4'h6: seg_code = 7'b1011111;
            4'h7: seg_code = 7'b1110000;
            4'h8: seg_code = 7'b1111111;
            4'h9: seg_code = 7'b1111011;
            4'hA: seg_code = 7'b1110111;
            4'hB: seg_code = 7'b0011111;
            4'hC: seg_code = 7'b1001110;
            4'hD: seg_code = 7'b0111101;
            4'hE: seg_code = 7'b1001111;
            default: seg_code = 7'b1000111;
        endcase
    endfunction

    assign tick = (cnt == CW'(SCAN_DIV - 1));
    assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

    // Prescaler, digit index, double-buffered value and blink phase; display swaps only at frame wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            fcnt    <= '0;
            phase   <= 1'b0;
            pending <= '0;
            display <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            if (bus.load) begin
                pending <= bus.value;
            end
            if (wrap) begin
                display <= bus.load ? bus.value : pending;
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // Select the current nibble, decide whether the digit is dark, and build active-high outputs
    always_comb begin
        cur_nib    = 4'd0;
        upper_zero = 1'b1;
        an_n       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i == int'(idx)) begin
                cur_nib = display[4*i +: 4];
            end
            if (i >= int'(idx) && display[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        dark = bus.blank_mask[idx]
            || (bus.blink_mask[idx] && phase)
            || (bus.lz_en && idx != '0 && upper_zero);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_n[i] = !dark && (i == int'(idx));
        end
        seg_n = dark ? 7'd0 : seg_code(cur_nib);
        dp_n  = !dark && bus.dp_in[idx];
    end

    // Registered outputs with polarity applied; frame_start marks the first cycle of digit 0
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.an          <= {NUM_DIGITS{ACTIVE_LOW}};
            bus.seg         <= {7{ACTIVE_LOW}};
            bus.dp          <= ACTIVE_LOW;
            bus.frame_start <= 1'b0;
        end else begin
            bus.an          <= an_n ^ {NUM_DIGITS{ACTIVE_LOW}};
            bus.seg         <= seg_n ^ {7{ACTIVE_LOW}};
            bus.dp          <= dp_n ^ ACTIVE_LOW;
            bus.frame_start <= (idx == '0) && (cnt == '0);
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench for seg7_scan_driver against a frame-level model
module tb_seg7_scan_driver;
    localparam int N  = 4;
    localparam int S  = 4;
    localparam int BF = 2;
    localparam int FL = N * S;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [6:0] code [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Frame-level model: output cycle k since reset release shows digit (k/S)%N of the frame k/FL
    int          k;
    bit          mvalid = 1'b0;
    logic [15:0] last_ld, nxt_disp, cur_disp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fs;
    int          md, mfr;
    bit          mph, mdark;
    logic [3:0]  mnib;

    always @(posedge clk) begin
        if (reset) begin
            k        = -1;
            last_ld  = '0;
            nxt_disp = '0;
            cur_disp = '0;
            exp_an   = 4'hF;
            exp_seg  = 7'h7F;
            exp_dp   = 1'b1;
            exp_fs   = 1'b0;
        end else begin
            k = k + 1;
            if (k > 0 && k % FL == 0) cur_disp = nxt_disp;
            md    = (k / S) % N;
            mfr   = k / FL;
            mph   = ((mfr / BF) % 2) == 1;
            mnib  = cur_disp[4*md +: 4];
            mdark = bus.blank_mask[md] || (bus.blink_mask[md] && mph)
                 || (bus.lz_en && md != 0 && (cur_disp >> (4*md)) == 16'd0);
            exp_an  = mdark ? 4'hF : ~(4'b0001 << md);
            exp_seg = mdark ? 7'h7F : ~code[mnib];
            exp_dp  = mdark ? 1'b1 : ~bus.dp_in[md];
            exp_fs  = (k % FL == 0);
            if (bus.load) last_ld = bus.value;
            if (k % FL == FL - 1) nxt_disp = last_ld;
        end
        mvalid = 1'b1;
    end

    // Every cycle: compare DUT outputs to the model and confirm at most one digit enabled
    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL model k=%0d act an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                         k, bus.an, bus.seg, bus.dp, bus.frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            checks++;
            if ($countones(~bus.an) > 1) begin
                errors++;
                $display("FAIL onehot act an=%b exp at most one low", bus.an);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (bus.frame_start === 1'b1) found = 1'b1;
        end
        chk("frame_start_timeout", 32'(found), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.value      = '0;
        bus.load       = 1'b0;
        bus.dp_in      = '0;
        bus.blank_mask = '0;
        bus.blink_mask = '0;
        bus.lz_en      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_an", 32'(bus.an), 32'b1111);
            chk("reset_seg", 32'(bus.seg), 32'b1111111);
            chk("reset_dp", 32'(bus.dp), 32'b1);
        end
        reset = 1'b0;
        step();
        chk("first_an", 32'(bus.an), 32'b1110);
        chk("first_seg", 32'(bus.seg), 32'b0000001);
        chk("first_fs", 32'(bus.frame_start), 32'b1);

        do_load(16'h1234);
        wait_fs();
        for (int d = 0; d < N; d++) begin
            logic [3:0] an_lit [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
            logic [6:0] seg_lit [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
            for (int c = 0; c < S; c++) begin
                chk("scan_an", 32'(bus.an), 32'(an_lit[d]));
                chk("scan_seg", 32'(bus.seg), 32'(seg_lit[d]));
                step();
            end
        end

        bus.lz_en = 1'b1;
        do_load(16'h0070);
        wait_fs();
        chk("lz70_d0_seg", 32'(bus.seg), 32'b0000001);
        repeat (S) step();
        chk("lz70_d1_an", 32'(bus.an), 32'b1101);
        chk("lz70_d1_seg", 32'(bus.seg), 32'b0001111);
        repeat (S) step();
        chk("lz70_d2_an", 32'(bus.an), 32'b1111);
        do_load(16'h0000);
        wait_fs();
        chk("lz00_d0_an", 32'(bus.an), 32'b1110);
        chk("lz00_d0_seg", 32'(bus.seg), 32'b0000001);
        repeat (S) step();
        chk("lz00_d1_an", 32'(bus.an), 32'b1111);
        bus.lz_en = 1'b0;

        bus.blink_mask = 4'b0001;
        bus.blank_mask = 4'b1000;
        bus.dp_in      = 4'b0100;
        do_load(16'h5678);
        repeat (6 * FL) step();

        for (int i = 0; i < 4000; i++) begin
            bus.load  = ($urandom % 6 == 0);
            bus.value = 16'($urandom);
            if (i % 23 == 0) begin
                bus.dp_in      = 4'($urandom);
                bus.blank_mask = 4'($urandom) & 4'($urandom) & 4'($urandom);
                bus.blink_mask = 4'($urandom);
                bus.lz_en      = 1'($urandom);
            end
            reset = ($urandom % 250 == 0);
            step();
        end
        reset    = 1'b0;
        bus.load = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display, used for the score and winner readout of the Fastest Finger First board. It latches a packed hex value, scans one digit at a time at a programmable refresh rate, and encodes each nibble to segments. It also supports per-digit blanking, per-digit blink, decimal points and leading-zero suppression. Display updates are tear-free because new values take effect only at a frame boundary.

## Interface
- NUM_DIGITS, 4, number of digits scanned (≥2)
- SCAN_DIV, 50000, clk cycles each digit is driven (≥2)
- BLINK_FRAMES, 64, full frames per blink half-period (≥1)
- ACTIVE_LOW, 1, 1: `an`, `seg`, `dp` are active-low; 0: active-high
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  packed hex digits; digit i = value[4i+3:4i], digit 0 = least significant
- load  in  1  capture `value` into pending register this cycle
- dp_in  in  NUM_DIGITS  decimal point enable per digit
- blank_mask  in  NUM_DIGITS  1 = digit permanently dark
- blink_mask  in  NUM_DIGITS  1 = digit dark during blink phase 1
- lz_en  in  1  leading-zero suppression enable
- an  out  NUM_DIGITS  digit enables, one-hot (per polarity) or all inactive
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a
- dp  out  1  decimal point
- frame_start  out  1  one-cycle pulse when digit 0 becomes active

## Operation
- Segment code (active-high {a..g}): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. With ACTIVE_LOW=1, all of `an`, `seg` and `dp` are bitwise inverted.
- Prescaler `cnt` counts 0..SCAN_DIV-1. `tick` = (cnt==SCAN_DIV-1). On tick, cnt←0 and `idx`←idx+1, wrapping from NUM_DIGITS-1 to 0.
- Wrap event = tick && idx==NUM_DIGITS-1.
- Two buffers, `pending` and `display`:
  - On load, pending←value.
  - On a wrap event, display←(load ? value : pending), so a load coincident with the wrap is used immediately.
  - A load mid-frame never alters the digits of the current frame.
- Blink: a frame counter increments on each wrap event and toggles `phase` every BLINK_FRAMES frames.
- Digit i is dark if any of the following holds:
  - blank_mask[i];
  - blink_mask[i] && phase;
  - lz_en && i≠0 && nibbles i..NUM_DIGITS-1 of display are all zero.
- Digit 0 is never zero-suppressed.
- Dark digit: `an` all inactive, `seg` all off, `dp` off.
- Lit digit: only an[idx] active, seg = code(display nibble idx), dp = dp_in[idx].
- Control inputs (`dp_in`, the masks, `lz_en`) are sampled live each cycle and are not buffered.

## Timing
- Outputs `an`, `seg`, `dp` and `frame_start` are registered, with 1-cycle latency from the idx/display/mask state.
- Each digit is driven for exactly SCAN_DIV cycles. A frame is NUM_DIGITS*SCAN_DIV cycles.
- frame_start is high for one cycle, in the first output cycle of digit 0 in each frame.
- Reset state:
  - internal: cnt=0, idx=0, pending=0, display=0, frame counter=0, phase=0;
  - outputs: `an` all inactive, `seg` all off, `dp` off, frame_start=0.
- Reset mid-operation: all state returns to the reset values on the next edge. Any pending load is discarded.
- First edge after reset deasserts: outputs show digit 0 = code(0), with frame_start=1.
- The idx and display update on the same edge, so digit 0 of a new frame always shows the new display value. No mixed-frame output is possible.
- No two `an` bits are ever simultaneously active.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1.
- **Reset:** hold reset 3 cycles.
  - During reset: an=1111, seg=1111111, dp=1.
  - First cycle after release: an=1110, seg=0000001 (code 0), frame_start=1.
- **Scan order:** load 0x1234; after the next frame_start, `an` steps 1110→1101→1011→0111, 4 cycles each.
  - seg follows as 1001100 (4), 0000110 (3), 0010010 (2), 1001111 (1).
- **Tear-free load:** load 0xABCD while idx=2.
  - Digits 2 and 3 keep showing the old values.
  - From the next frame_start, digit 0 shows seg=1000010 (d).
  - Load asserted exactly on the wrap cycle must show the new value in that same next frame.
- **Leading-zero suppression:** lz_en=1.
  - value 0x0070: digits 1 (7) and 0 (0) lit; digits 2 and 3 have `an` inactive.
  - value 0x0000: only digit 0 lit, showing 0.
- **Blink and blank:** blink_mask=0001, blank_mask=1000, dp_in=0100.
  - Digit 0 is lit for 2 frames, then dark for 2 frames, repeating.
  - Digit 3 is never lit.
  - dp=0 only while an=1011.
- **Mid-frame reset:** assert reset during digit 2 after loading 0x5678.
  - Next edge: reset outputs.
  - After release: display shows 0x0000 starting at digit 0.
